// File: rtl/gray_ptr_sync.sv
// gray_ptr_sync: destination-domain synchroniser for a Gray-coded async-FIFO
// pointer. Carries the far-domain pointer through a flop chain, presents it in
// Gray and binary form, reports the per-cycle pointer advance and tracks Gray
// integrity violations with a sticky flag and a saturating counter.
// STAGES is expected to lie in 2..4; SIZE must be at least 2.
module gray_ptr_sync #(
    parameter int SIZE       = 8,
    parameter int STAGES     = 2,
    parameter int CHECK_GRAY = 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [SIZE-1:0] i_gptr_in,
    input  logic            i_err_clr,
    output logic [SIZE-1:0] o_sptr_gray,
    output logic [SIZE-1:0] o_sptr_bin,
    output logic            o_ptr_upd,
    output logic [SIZE-1:0] o_ptr_delta,
    output logic            o_gray_err,
    output logic [7:0]      o_err_cnt
);

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [SIZE-1:0] g2b(input logic [SIZE-1:0] g);
        logic [SIZE-1:0] b;
        b[SIZE-1] = g[SIZE-1];
        for (int i = SIZE - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // True when more than one bit is set (clearing the lowest set bit leaves something).
    function automatic logic multi_bit(input logic [SIZE-1:0] d);
        return (d & (d - SIZE'(1))) != '0;
    endfunction

    // Saturating increment of the 8-bit violation count.
    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    logic [SIZE-1:0] r_sync [STAGES];
    logic [2:0]      r_prime;
    logic [SIZE-1:0] r_sptr_gray;
    logic [SIZE-1:0] r_sptr_bin;
    logic            r_ptr_upd;
    logic [SIZE-1:0] r_ptr_delta;

    logic [SIZE-1:0] w_s;
    logic [SIZE-1:0] w_s_bin;
    logic [SIZE-1:0] w_diff;
    logic            w_primed;
    logic            w_gray_err;
    logic [7:0]      w_err_cnt;

    assign w_s      = r_sync[STAGES-1];
    assign w_s_bin  = g2b(w_s);
    assign w_diff   = w_s ^ r_sptr_gray;
    assign w_primed = (r_prime == 3'(STAGES));

    // Synchroniser chain: only stage 0 ever samples the asynchronous pointer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_sync[k] <= '0;
            end
        end else begin
            r_sync[0] <= i_gptr_in;
            for (int k = 1; k < STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    // Priming counter: blocks comparisons until the chain holds post-reset samples.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prime <= '0;
        end else if (!w_primed) begin
            r_prime <= r_prime + 3'd1;
        end
    end

    // Output stage: pointer always tracks the chain; advance reporting only once primed.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sptr_gray <= '0;
            r_sptr_bin  <= '0;
            r_ptr_upd   <= 1'b0;
            r_ptr_delta <= '0;
        end else begin
            r_sptr_gray <= w_s;
            r_sptr_bin  <= w_s_bin;
            if (w_primed) begin
                // An unchanged pointer yields equal binaries, so delta is 0 with no pulse.
                r_ptr_upd   <= (w_diff != '0);
                r_ptr_delta <= w_s_bin - r_sptr_bin;
            end else begin
                r_ptr_upd   <= 1'b0;
                r_ptr_delta <= '0;
            end
        end
    end

    generate
        if (CHECK_GRAY != 0) begin : g_check
            logic       r_gray_err;
            logic [7:0] r_err_cnt;
            logic       w_viol;

            assign w_viol = w_primed && multi_bit(w_diff);

            // Violation tracking: a violation on the same edge as a clear takes precedence.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_gray_err <= 1'b0;
                    r_err_cnt  <= 8'd0;
                end else if (w_viol) begin
                    r_gray_err <= 1'b1;
                    r_err_cnt  <= i_err_clr ? 8'd1 : sat_inc(r_err_cnt);
                end else if (i_err_clr) begin
                    r_gray_err <= 1'b0;
                    r_err_cnt  <= 8'd0;
                end
            end

            assign w_gray_err = r_gray_err;
            assign w_err_cnt  = r_err_cnt;
        end else begin : g_nocheck
            logic w_unused_clr;
            assign w_unused_clr = i_err_clr;
            assign w_gray_err   = 1'b0;
            assign w_err_cnt    = 8'd0;
        end
    endgenerate

    assign o_sptr_gray = r_sptr_gray;
    assign o_sptr_bin  = r_sptr_bin;
    assign o_ptr_upd   = r_ptr_upd;
    assign o_ptr_delta = r_ptr_delta;
    assign o_gray_err  = w_gray_err;
    assign o_err_cnt   = w_err_cnt;

endmodule
